// File: rtl/i2c_slave_cmdqueue_pkg.sv
// Shared register map, command addresses and TPU opcodes for the I2C command queue.
// Also provides the helper that lays out a 48-bit TPU command from its bytes.
package i2c_slave_cmdqueue_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Operand register addresses (0x00..0x09) and the status register.
  localparam logic [7:0] I2C_CHARACTER = 8'h00;
  localparam logic [7:0] I2C_XTEXT     = 8'h01;
  localparam logic [7:0] I2C_YTEXT     = 8'h02;
  localparam logic [7:0] I2C_ATTR1     = 8'h03;
  localparam logic [7:0] I2C_ATTR2     = 8'h04;
  localparam logic [7:0] I2C_MCHAR     = 8'h05;
  localparam logic [7:0] I2C_MATTR1    = 8'h06;
  localparam logic [7:0] I2C_MATTR2    = 8'h07;
  localparam logic [7:0] I2C_XEND      = 8'h08;
  localparam logic [7:0] I2C_YEND      = 8'h09;
  localparam logic [7:0] I2C_OPR_END   = 8'h0A;
  localparam logic [7:0] I2C_STATUS    = 8'h7F;

  localparam int NUM_OPR = 10;

  // Command addresses; writing any of these pushes a command.
  localparam logic [7:0] I2C_CLEARSCREEN = 8'h80;
  localparam logic [7:0] I2C_PRINT       = 8'h81;
  localparam logic [7:0] I2C_LOCATE      = 8'h82;
  localparam logic [7:0] I2C_SETATTR     = 8'h83;
  localparam logic [7:0] I2C_SETMASK     = 8'h84;
  localparam logic [7:0] I2C_FILLAREA    = 8'h85;

  typedef enum logic [7:0] {
    TPU_CLEARSCREEN = 8'h01,
    TPU_PRINT       = 8'h02,
    TPU_LOCATE      = 8'h03,
    TPU_SETATTR     = 8'h04,
    TPU_SETMASK     = 8'h05,
    TPU_FILLAREA    = 8'h06
  } tpu_op_e;

  function automatic logic [47:0] pack_cmd(input tpu_op_e op, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    return {16'h0000, b3, b2, b1, op};
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Show-ahead command FIFO: the head is visible combinationally, 0 while empty.
// Pointers and count reset asynchronously; storage has no reset.
module i2c_cmd_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_slave_cmdqueue.sv
// I2C register bank that builds TPU commands and queues them toward the TPU.
// Optional cursor auto-advance on PRINT is enabled by defining I2C_CMDQ_AUTOADVANCE_EN.
module i2c_slave_cmdqueue
  import i2c_slave_cmdqueue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CMD_W     = 48,
  parameter int TEXT_COLS = 80,
  parameter int TEXT_ROWS = 25
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   addr,
  input  logic [7:0]                   dataIn,
  input  logic                         writeEn,
  output logic [7:0]                   dataOut,
  output logic [CMD_W-1:0]             command,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (CMD_W < 48 || TEXT_COLS < 2 || TEXT_COLS > 256 || TEXT_ROWS < 2 || TEXT_ROWS > 256)
  begin : g_bad_geometry
    $error("CMD_W must hold 6 bytes and the text grid must fit 8-bit cursor registers");
  end

  localparam int IDX_CHAR = 0, IDX_X = 1, IDX_Y = 2, IDX_A1 = 3, IDX_A2 = 4;
  localparam int IDX_MCHAR = 5, IDX_MA1 = 6, IDX_MA2 = 7, IDX_XEND = 8, IDX_YEND = 9;

  logic [7:0]       opr [NUM_OPR];
  logic [7:0]       read_data;
  logic [47:0]      built_cmd;
  logic             cmd_known;
  logic             cmd_push;
  logic             fifo_full;
  logic             fifo_empty;

  // Commands are built from the operand values as they stand before this edge.
  always_comb begin
    cmd_known = TRUE;
    built_cmd = '0;
    case (addr)
      I2C_CLEARSCREEN: built_cmd = pack_cmd(TPU_CLEARSCREEN, 8'h00, 8'h00, 8'h00);
      I2C_PRINT:       built_cmd = pack_cmd(TPU_PRINT, opr[IDX_CHAR], 8'h00, 8'h00);
      I2C_LOCATE:      built_cmd = pack_cmd(TPU_LOCATE, opr[IDX_X], opr[IDX_Y], 8'h00);
      I2C_SETATTR:     built_cmd = pack_cmd(TPU_SETATTR, opr[IDX_A1], opr[IDX_A2], 8'h00);
      I2C_SETMASK:     built_cmd = pack_cmd(TPU_SETMASK, opr[IDX_MCHAR], opr[IDX_MA1],
                                            opr[IDX_MA2]);
      I2C_FILLAREA:    built_cmd = pack_cmd(TPU_FILLAREA, opr[IDX_XEND], opr[IDX_YEND],
                                            opr[IDX_CHAR]);
      default:         cmd_known = FALSE;
    endcase
  end

  assign cmd_push  = writeEn && cmd_known;
  assign cmd_valid = !fifo_empty;

  always_comb begin
    read_data = 8'h00;
    if (addr < I2C_OPR_END)
      read_data = opr[addr[3:0]];
    else if (addr == I2C_STATUS)
      read_data = {overflow, 7'(fifo_level)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OPR; i++) opr[i] <= 8'h00;
      dataOut  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      dataOut <= read_data;
      if (writeEn && addr < I2C_OPR_END) opr[addr[3:0]] <= dataIn;
      if (writeEn && addr == I2C_STATUS) overflow <= 1'b0;
      // Fullness is judged before the edge, so a same-cycle pop cannot rescue the push.
      if (cmd_push && fifo_full) overflow <= 1'b1;
`ifdef I2C_CMDQ_AUTOADVANCE_EN
      if (cmd_push && !fifo_full && addr == I2C_PRINT) begin
        if (opr[IDX_X] == 8'(TEXT_COLS - 1)) begin
          opr[IDX_X] <= 8'h00;
          opr[IDX_Y] <= (opr[IDX_Y] == 8'(TEXT_ROWS - 1)) ? 8'h00 : opr[IDX_Y] + 8'd1;
        end else begin
          opr[IDX_X] <= opr[IDX_X] + 8'd1;
        end
      end
`endif
    end
  end

  i2c_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_push),
    .push_data (CMD_W'(built_cmd)),
    .pop       (cmd_ready),
    .head      (command),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule
